// File: rtl/key_chord_debouncer.sv
// key_chord_debouncer
// Synchronizes and debounces four raw push-buttons, gathers every button
// pressed during one gesture into a 4-bit chord, and publishes that chord as a
// held key_out level plus a one-cycle key_valid strobe once all buttons are
// released. busy reports that a gesture is being collected.
module key_chord_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_raw,
  output logic [3:0] key_out,
  output logic       key_valid,
  output logic       busy
);

  localparam int unsigned     CNT_W        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  // Raw level of a released button; the synchronizer resets to it so that a
  // button held through reset is seen as a fresh press afterwards.
  localparam logic [3:0]       RELEASED_RAW = ACTIVE_LOW ? 4'b1111 : 4'b0000;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Synchronizer and debounce state
  logic [3:0]            meta_q,   meta_d;
  logic [3:0]            sync_q,   sync_d;
  logic [3:0]            stable_q, stable_d;
  logic [3:0][CNT_W-1:0] cnt_q,    cnt_d;
  logic [3:0]            pressed;

  // Gesture FSM state and registered outputs
  state_t     state_q,     state_d;
  logic [3:0] chord_q,     chord_d;
  logic [3:0] key_out_q,   key_out_d;
  logic       key_valid_q, key_valid_d;
  logic       busy_q,      busy_d;

  // Two-stage synchronizer next-state and pressed=1 normalization.
  always_comb begin
    meta_d = key_raw;
    sync_d = meta_q;
    if (ACTIVE_LOW) begin
      pressed = ~sync_q;
    end else begin
      pressed = sync_q;
    end
  end

  // Per-bit debounce: a bit flips only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (pressed[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = ~stable_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Synchronizer and debounce registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= RELEASED_RAW;
      sync_q   <= RELEASED_RAW;
      stable_q <= 4'b0000;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Gesture FSM next-state: accumulate the chord while any button is stable
  // pressed, publish it on the edge where everything reads released.
  always_comb begin
    state_d     = state_q;
    chord_d     = chord_q;
    key_out_d   = key_out_q;
    key_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (stable_q != 4'b0000) begin
          chord_d = stable_q;
          state_d = COLLECT;
        end else begin
          chord_d = 4'b0000;
        end
      end
      COLLECT: begin
        if (stable_q != 4'b0000) begin
          chord_d = chord_q | stable_q;
        end else begin
          key_out_d   = chord_q;
          key_valid_d = 1'b1;
          chord_d     = 4'b0000;
          state_d     = IDLE;
        end
      end
      default: begin
        chord_d = 4'b0000;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == COLLECT);
  end

  // Gesture FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      chord_q     <= 4'b0000;
      key_out_q   <= 4'b0000;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chord_q     <= chord_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_key_chord_debouncer.sv
// Bench for key_chord_debouncer with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
// Inputs are driven 1 time unit after a rising edge; outputs are checked at
// that same point (edge + 1) or by the negedge scoreboard monitor.
// With DEBOUNCE_CYCLES=4, a raw change driven after edge E0 makes the stable
// bit change at E6 (2 sync + 4 debounce) and busy / publish occur at E7.
module tb_key_chord_debouncer;

  logic       clk;
  logic       rst;
  logic [3:0] key_raw;
  logic [3:0] key_out;
  logic       key_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int pushes   = 0;
  int pulses   = 0;

  logic [3:0] sb_q[$];
  logic [3:0] mon_exp;

  typedef struct {
    logic [3:0] raw;   // active-low raw pattern held for the gesture
    int         hold;  // cycles held (>= 8)
    logic [3:0] exp;   // chord expected on key_out (= ~raw)
  } vec_t;

  vec_t vecs[5];

  key_chord_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key_raw),
    .key_out  (key_out),
    .key_valid(key_valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges and stop 1 unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every key_valid pulse pops one expected chord.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulses++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_valid actual key_out=%b required=no pulse", key_out);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("sb_key_out", {28'd0, key_out}, {28'd0, mon_exp});
      end
    end
  end

  // Absolute time bound.
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Gesture table (raw is active-low, so the published chord is ~raw).
    vecs[0] = '{4'b1110, 10, 4'b0001};
    vecs[1] = '{4'b1100,  8, 4'b0011};
    vecs[2] = '{4'b0000, 12, 4'b1111};
    vecs[3] = '{4'b0111,  9, 4'b1000};
    vecs[4] = '{4'b1010,  8, 4'b0101};

    rst     = 1'b0;
    key_raw = 4'b1111;

    // 1. Asynchronous reset mid-cycle, then 20 quiet cycles.
    cyc(2);
    #3 rst = 1'b1;
    #1;
    chk("rst_key_out",   {28'd0, key_out},   32'h0);
    chk("rst_key_valid", {31'd0, key_valid}, 32'h0);
    chk("rst_busy",      {31'd0, busy},      32'h0);
    cyc(2);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      chk("post_rst_key_out",   {28'd0, key_out},   32'h0);
      chk("post_rst_key_valid", {31'd0, key_valid}, 32'h0);
      chk("post_rst_busy",      {31'd0, busy},      32'h0);
    end

    // 2. Table-driven gestures with exact press / release latency checks.
    for (int i = 0; i < 5; i++) begin
      key_raw = vecs[i].raw;
      cyc(6);
      chk("press_busy_early", {31'd0, busy}, 32'h0);
      cyc(1);
      chk("press_busy_rise", {31'd0, busy}, 32'h1);
      cyc(vecs[i].hold - 7);
      chk("hold_busy", {31'd0, busy}, 32'h1);
      key_raw = 4'b1111;
      sb_q.push_back(vecs[i].exp);
      pushes++;
      cyc(6);
      chk("release_busy_still", {31'd0, busy},      32'h1);
      chk("release_no_valid",   {31'd0, key_valid}, 32'h0);
      cyc(1);
      chk("publish_valid",   {31'd0, key_valid}, 32'h1);
      chk("publish_key_out", {28'd0, key_out},   {28'd0, vecs[i].exp});
      chk("publish_busy",    {31'd0, busy},      32'h0);
      cyc(1);
      chk("valid_one_cycle", {31'd0, key_valid}, 32'h0);
      cyc(3);
      chk("key_out_held", {28'd0, key_out}, {28'd0, vecs[i].exp});
    end

    // 3. Staggered chord: button 1, then button 3 six cycles later;
    //    release button 1 first, then button 3.
    key_raw = 4'b1110;
    cyc(6);
    key_raw = 4'b1010;
    cyc(8);
    chk("stagger_busy_a", {31'd0, busy}, 32'h1);
    key_raw = 4'b1011;
    cyc(8);
    chk("stagger_busy_b",   {31'd0, busy},      32'h1);
    chk("stagger_no_valid", {31'd0, key_valid}, 32'h0);
    key_raw = 4'b1111;
    sb_q.push_back(4'b0101);
    pushes++;
    cyc(6);
    chk("stagger_busy_c", {31'd0, busy}, 32'h1);
    cyc(1);
    chk("stagger_valid",   {31'd0, key_valid}, 32'h1);
    chk("stagger_key_out", {28'd0, key_out},   32'h5);
    cyc(1);
    chk("stagger_valid_drop", {31'd0, key_valid}, 32'h0);

    // 4. Bounce rejection on bit 1: 2 low / 2 high, five times.
    for (int r = 0; r < 5; r++) begin
      key_raw = 4'b1101;
      cyc(2);
      chk("bounce_busy_lo", {31'd0, busy}, 32'h0);
      key_raw = 4'b1111;
      cyc(2);
      chk("bounce_busy_hi", {31'd0, busy}, 32'h0);
    end
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      chk("bounce_tail_busy",  {31'd0, busy},      32'h0);
      chk("bounce_tail_valid", {31'd0, key_valid}, 32'h0);
    end
    chk("bounce_key_out_kept", {28'd0, key_out}, 32'h5);

    // 5. Release bounce: chord 4'b1100 (raw 4'b0011); bit 2 glitches back
    //    to pressed for 3 cycles during the release.
    key_raw = 4'b0011;
    cyc(10);
    chk("relb_busy", {31'd0, busy}, 32'h1);
    key_raw = 4'b1111;
    sb_q.push_back(4'b1100);
    pushes++;
    cyc(2);
    key_raw = 4'b1011;
    cyc(3);
    key_raw = 4'b1111;
    cyc(6);
    chk("relb_busy_late", {31'd0, busy},      32'h1);
    chk("relb_no_valid",  {31'd0, key_valid}, 32'h0);
    cyc(1);
    chk("relb_valid",   {31'd0, key_valid}, 32'h1);
    chk("relb_key_out", {28'd0, key_out},   32'hc);
    cyc(10);
    chk("relb_key_out_held", {28'd0, key_out}, 32'hc);

    // 6. Reset mid-gesture while holding chord 4'b0011 (raw 4'b1100).
    key_raw = 4'b1100;
    cyc(10);
    chk("rmid_busy_before", {31'd0, busy}, 32'h1);
    #3 rst = 1'b1;
    #1;
    chk("rmid_busy",      {31'd0, busy},      32'h0);
    chk("rmid_key_valid", {31'd0, key_valid}, 32'h0);
    chk("rmid_key_out",   {28'd0, key_out},   32'h0);
    cyc(2);
    rst = 1'b0;
    cyc(6);
    chk("rmid_redebounce_early", {31'd0, busy}, 32'h0);
    cyc(1);
    chk("rmid_redebounce_busy", {31'd0, busy},    32'h1);
    chk("rmid_no_old_publish",  {28'd0, key_out}, 32'h0);
    cyc(5);
    key_raw = 4'b1111;
    sb_q.push_back(4'b0011);
    pushes++;
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) begin
      cyc(1);
    end
    chk("rmid_new_publish_seen", sb_q.size(), 32'h0);
    cyc(2);
    chk("rmid_new_key_out", {28'd0, key_out}, 32'h3);
    chk("rmid_busy_after",  {31'd0, busy},    32'h0);

    // Scoreboard closure.
    cyc(5);
    chk("sb_empty",       sb_q.size(), 32'h0);
    chk("pulse_count",    pulses,      pushes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
